// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - tempo-driven beat stepper feeding a tone table into the PWM generator
module music_sequencer #(
  parameter int TICK_DIV = 8,
  parameter int BEAT_W   = 8,
  parameter int LEN      = 256,
  parameter int TONE_W   = 32,
  parameter int SILENCE  = 20000,
  parameter int ARTIC    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic              reverse,
  input  logic [1:0]        tempo,
  input  logic [TONE_W-1:0] tone_in,
  output logic [BEAT_W-1:0] beat_num,
  output logic [TONE_W-1:0] tone,
  output logic              playing,
  output logic              beat_tick,
  output logic              done
);

  // Counter holds up to 2*TICK_DIV-1, the longest step at half tempo.
  localparam int CW = $clog2(2 * TICK_DIV);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLAY  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam logic [BEAT_W-1:0] LAST_IDX = BEAT_W'(LEN - 1);
  localparam logic [TONE_W-1:0] SIL      = TONE_W'(SILENCE);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              dir;
  logic [CW-1:0]     p_m1;
  logic [CW-1:0]     art_thr;
  logic              step_end;
  logic              at_last;
  logic              silent_tail;
  logic [BEAT_W-1:0] first_idx;
  logic [BEAT_W-1:0] wrap_idx;
  logic [BEAT_W-1:0] next_idx;

  // Step length minus one and articulation threshold for the selected tempo.
  always_comb begin
    p_m1    = CW'(TICK_DIV - 1);
    art_thr = CW'(TICK_DIV - ARTIC);
    case (tempo)
      2'd0: begin
        p_m1    = CW'(2 * TICK_DIV - 1);
        art_thr = CW'(2 * TICK_DIV - ARTIC);
      end
      2'd1: begin
        p_m1    = CW'(TICK_DIV - 1);
        art_thr = CW'(TICK_DIV - ARTIC);
      end
      2'd2: begin
        p_m1    = CW'(TICK_DIV / 2 - 1);
        art_thr = CW'(TICK_DIV / 2 - ARTIC);
      end
      default: begin
        p_m1    = CW'(TICK_DIV / 4 - 1);
        art_thr = CW'(TICK_DIV / 4 - ARTIC);
      end
    endcase
  end

  // >= rather than == so a faster tempo chosen mid-step ends the step at once.
  assign step_end    = (cnt >= p_m1);
  assign silent_tail = (ARTIC > 0) && (cnt >= art_thr);
  assign at_last     = dir ? (beat_num == '0) : (beat_num == LAST_IDX);
  assign first_idx   = reverse ? LAST_IDX : '0;
  assign wrap_idx    = dir ? LAST_IDX : '0;
  assign next_idx    = dir ? (beat_num - BEAT_W'(1)) : (beat_num + BEAT_W'(1));
  assign playing     = (state == S_PLAY) || (state == S_PAUSE);

  // Playback state machine: position, step counter, direction and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat_num  <= '0;
      cnt       <= '0;
      dir       <= 1'b0;
      beat_tick <= 1'b0;
      done      <= 1'b0;
    end else begin
      beat_tick <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!stop && start) begin
            state    <= S_PLAY;
            beat_num <= first_idx;
            cnt      <= '0;
            dir      <= reverse;
          end
        end
        default: begin
          if (stop) begin
            state    <= S_IDLE;
            beat_num <= '0;
            cnt      <= '0;
          end else if (start) begin
            state    <= S_PLAY;
            beat_num <= first_idx;
            cnt      <= '0;
            dir      <= reverse;
          end else if (pause) begin
            // Freeze here; the edge that releases pause does the counting
            // this edge skipped, so no cycle is lost or duplicated.
            state <= S_PAUSE;
          end else begin
            state <= S_PLAY;
            if (step_end) begin
              cnt <= '0;
              if (at_last) begin
                if (loop_en) begin
                  beat_num  <= wrap_idx;
                  beat_tick <= 1'b1;
                end else begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end
              end else begin
                beat_num  <= next_idx;
                beat_tick <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
      endcase
    end
  end

  // Tone output: table value while sounding, silence when idle, paused or in the articulation gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone <= SIL;
    end else if ((state == S_PLAY) && !silent_tail) begin
      tone <= tone_in;
    end else begin
      tone <= SIL;
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - directed self-checking bench for music_sequencer
module tb_music_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause;
  logic        loop_en;
  logic        reverse;
  logic [1:0]  tempo;
  logic [31:0] tone_in;
  logic [31:0] tone_in_a;
  logic [7:0]  beat_num;
  logic [7:0]  beat_num_a;
  logic [31:0] tone;
  logic [31:0] tone_a;
  logic        playing;
  logic        playing_a;
  logic        beat_tick;
  logic        beat_tick_a;
  logic        done;
  logic        done_a;

  int checks = 0;
  int errors = 0;

  // Note table: beat b -> 1000 + 100*b.
  assign tone_in   = 32'd1000 + 32'd100 * {24'd0, beat_num};
  assign tone_in_a = 32'd1000 + 32'd100 * {24'd0, beat_num_a};

  music_sequencer #(
    .TICK_DIV(8), .BEAT_W(8), .LEN(4), .TONE_W(32), .SILENCE(20000), .ARTIC(0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .reverse(reverse), .tempo(tempo), .tone_in(tone_in),
    .beat_num(beat_num), .tone(tone), .playing(playing),
    .beat_tick(beat_tick), .done(done)
  );

  music_sequencer #(
    .TICK_DIV(8), .BEAT_W(8), .LEN(4), .TONE_W(32), .SILENCE(20000), .ARTIC(1)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .reverse(reverse), .tempo(tempo), .tone_in(tone_in_a),
    .beat_num(beat_num_a), .tone(tone_a), .playing(playing_a),
    .beat_tick(beat_tick_a), .done(done_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse start so the following check point is "after edge 0".
  task automatic kick();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    loop_en = 1'b0; reverse = 1'b0; tempo = 2'd1;
    cyc(2);
    chk("rst_beat", beat_num, 0);
    chk("rst_tone", tone, 20000);
    chk("rst_playing", playing, 0);
    chk("rst_tick", beat_tick, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    cyc(1);

    // One-shot forward, tempo 1x
    kick();                                  // after edge 0
    chk("os_e0_beat", beat_num, 0);
    chk("os_e0_playing", playing, 1);
    chk("os_e0_tone", tone, 20000);
    cyc(7);                                  // after edge 7
    chk("os_e7_beat", beat_num, 0);
    chk("os_e7_tick", beat_tick, 0);
    chk("os_e7_tone", tone, 1000);
    chk("art_e7_tone", tone_a, 1000);
    cyc(1);                                  // after edge 8
    chk("os_e8_beat", beat_num, 1);
    chk("os_e8_tick", beat_tick, 1);
    chk("os_e8_tone", tone, 1000);
    chk("art_e8_tone", tone_a, 20000);
    cyc(1);                                  // after edge 9
    chk("os_e9_tick", beat_tick, 0);
    chk("os_e9_tone", tone, 1100);
    chk("art_e9_tone", tone_a, 1100);
    cyc(15);                                 // after edge 24
    chk("os_e24_beat", beat_num, 3);
    chk("os_e24_tick", beat_tick, 1);
    cyc(7);                                  // after edge 31
    chk("os_e31_done", done, 0);
    chk("os_e31_playing", playing, 1);
    cyc(1);                                  // after edge 32
    chk("os_e32_done", done, 1);
    chk("os_e32_tick", beat_tick, 0);
    chk("os_e32_playing", playing, 0);
    chk("os_e32_beat", beat_num, 3);
    chk("os_e32_tone", tone, 1300);
    cyc(1);                                  // after edge 33
    chk("os_e33_done", done, 0);
    chk("os_e33_tone", tone, 20000);
    chk("os_e33_beat", beat_num, 3);

    // Loop forward
    loop_en = 1'b1;
    kick();
    cyc(24);
    chk("lp_e24_beat", beat_num, 3);
    cyc(8);                                  // after edge 32
    chk("lp_e32_beat", beat_num, 0);
    chk("lp_e32_tick", beat_tick, 1);
    chk("lp_e32_done", done, 0);
    chk("lp_e32_playing", playing, 1);
    halt();
    chk("stop_playing", playing, 0);
    chk("stop_beat", beat_num, 0);
    chk("stop_done", done, 0);

    // Loop reverse: 3,2,1,0,3
    reverse = 1'b1;
    kick();
    chk("rv_e0_beat", beat_num, 3);
    cyc(8);
    chk("rv_e8_beat", beat_num, 2);
    cyc(16);
    chk("rv_e24_beat", beat_num, 0);
    cyc(8);
    chk("rv_e32_beat", beat_num, 3);
    chk("rv_e32_tick", beat_tick, 1);
    halt();
    reverse = 1'b0;
    loop_en = 1'b0;

    // Pause 5 cycles at counter 3 of step 1
    kick();
    cyc(11);                                 // after edge 11, cnt=3
    pause = 1'b1;
    cyc(1);                                  // after edge 12
    chk("ps_e12_playing", playing, 1);
    chk("ps_e12_tone", tone, 1100);
    cyc(1);                                  // after edge 13
    chk("ps_e13_tone", tone, 20000);
    cyc(3);                                  // after edge 16
    chk("ps_e16_beat", beat_num, 1);
    pause = 1'b0;
    cyc(1);                                  // after edge 17
    chk("ps_e17_tone", tone, 20000);
    chk("ps_e17_beat", beat_num, 1);
    cyc(1);                                  // after edge 18
    chk("ps_e18_tone", tone, 1100);
    cyc(2);                                  // after edge 20
    chk("ps_e20_beat", beat_num, 1);
    chk("ps_e20_tick", beat_tick, 0);
    cyc(1);                                  // after edge 21
    chk("ps_e21_beat", beat_num, 2);
    chk("ps_e21_tick", beat_tick, 1);
    halt();

    // Tempo 0.5x, then switch to 2x at cnt=10, then 4x
    tempo = 2'd0;
    kick();
    cyc(15);
    chk("t0_e15_beat", beat_num, 0);
    cyc(1);
    chk("t0_e16_beat", beat_num, 1);
    chk("t0_e16_tick", beat_tick, 1);
    cyc(10);                                 // after edge 26, cnt=10
    chk("t0_e26_beat", beat_num, 1);
    tempo = 2'd2;
    cyc(1);                                  // after edge 27
    chk("t2_e27_beat", beat_num, 2);
    chk("t2_e27_tick", beat_tick, 1);
    tempo = 2'd3;
    cyc(1);                                  // after edge 28
    chk("t3_e28_beat", beat_num, 2);
    chk("t3_e28_tick", beat_tick, 0);
    cyc(1);                                  // after edge 29
    chk("t3_e29_beat", beat_num, 3);
    chk("t3_e29_tick", beat_tick, 1);
    halt();
    tempo = 2'd1;

    // start and stop together in IDLE
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("ss_playing", playing, 0);
    cyc(1);
    chk("ss_tone", tone, 20000);

    // Reset mid-song at beat 2, then restart
    kick();
    cyc(16);
    chk("mr_e16_beat", beat_num, 2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mr_beat", beat_num, 0);
    chk("mr_playing", playing, 0);
    chk("mr_tone", tone, 20000);
    chk("mr_tick", beat_tick, 0);
    chk("mr_done", done, 0);
    kick();
    chk("mr_rs_beat", beat_num, 0);
    chk("mr_rs_playing", playing, 1);
    cyc(8);
    chk("mr_rs_e8_beat", beat_num, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
- Tempo-driven playback engine for the tone ROMs (beat index -> tone frequency) that feed the buzzer/audio PWM generator.
- Steps a beat index through an external combinational note table and registers the returned tone.
- Adds play/pause/stop control, selectable tempo, forward/reverse playback, loop or one-shot mode, and note articulation gaps.
- Sits between the control/debounce logic and the PWM tone generator.

Parameters:
- TICK_DIV, 8, clk cycles per 1/4-beat step at tempo 1x. Must be a multiple of 4 and ≥ 8.
- BEAT_W, 8, width of the beat index.
- LEN, 256, number of steps in the song, 2 ≤ LEN ≤ 2^BEAT_W.
- TONE_W, 32, tone frequency width.
- SILENCE, 20000, tone value emitted when not sounding (above audible range).
- ARTIC, 0, clk cycles of forced silence at the end of every step. 0 disables it; must be < TICK_DIV/4.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin or restart playback
- stop  in  1  one-cycle pulse: abort to idle
- pause  in  1  level: hold position while high
- loop_en  in  1  level: wrap at song end instead of finishing
- reverse  in  1  level, sampled on start: play from LEN-1 down to 0
- tempo  in  2  0 = 0.5x, 1 = 1x, 2 = 2x, 3 = 4x
- tone_in  in  TONE_W  table output for beat_num (combinational, same cycle)
- beat_num  out  BEAT_W  current step index, registered
- tone  out  TONE_W  registered tone for PWM
- playing  out  1  high in PLAY or PAUSE
- beat_tick  out  1  one-cycle pulse on each step advance
- done  out  1  one-cycle pulse when a one-shot song finishes

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE, beat_num 0, tick counter 0, tone SILENCE
  - playing, beat_tick and done all 0
  - Reset overrides every other input, including when it arrives mid-song.
- Step period P, selected by tempo: 0 -> 2*TICK_DIV, 1 -> TICK_DIV, 2 -> TICK_DIV/2, 3 -> TICK_DIV/4.
- States: IDLE, PLAY, PAUSE.
- Input priority: stop > start > pause.
- IDLE:
  - tone is SILENCE; beat_num holds its last value.
  - On start: move to PLAY, load beat_num with 0 (or LEN-1 if reverse=1), clear the counter, latch the direction.
- PLAY:
  - The counter increments each cycle.
  - Step end is counter ≥ P-1. Using ≥ means a tempo change takes effect immediately: if the counter already exceeds the new P-1, the step ends on the next cycle.
  - At step end: counter cleared, beat_tick=1 for one cycle, beat_num moves one step in the latched direction.
- End of song (last index is LEN-1 forward, 0 reverse), handled at that step's end:
  - loop_en=1: wrap to the first index (0 or LEN-1); beat_tick pulses.
  - loop_en=0: go to IDLE, done=1 for one cycle, no beat_tick, beat_num holds the last index.
  - loop_en is sampled only at that step end.
- PLAY with pause=1: move to PAUSE on the next edge; the counter and beat_num freeze.
- PAUSE:
  - tone is SILENCE.
  - pause=0 returns to PLAY; the counter resumes from its frozen value with no lost or extra cycles.
- stop in PLAY or PAUSE: IDLE on the next edge, beat_num cleared to 0, no done pulse.
- start in PLAY or PAUSE: restart from the first index and re-latch the direction; a pause held high still applies on the following cycle.
- tone register:
  - If the state is PLAY and not (ARTIC>0 and counter ≥ P-ARTIC), tone <= tone_in; otherwise tone <= SILENCE.
  - tone therefore lags beat_num by one clk cycle.
- Width rules:
  - beat_num wraps modulo LEN, never modulo 2^BEAT_W.
  - The counter is sized for 2*TICK_DIV-1 and never overflows.

Test Plan:
- TICK_DIV=8, LEN=4, tempo=1, loop_en=0, start at cycle 0 -> beat_num 0,1,2,3, each held 8 cycles. beat_tick at cycles 8, 16, 24. done at cycle 32, then IDLE with playing=0. tone equals tone_in delayed by 1 cycle.
- Same setup with loop_en=1 -> after 3 the index wraps to 0 with a beat_tick and no done. reverse=1 gives the sequence 3,2,1,0,3.
- pause high for 5 cycles starting at counter=3 of step 1 -> tone is SILENCE during the pause. Step 1 then lasts exactly 8 active PLAY cycles plus the 5-cycle pause.
- tempo 0 -> 16 cycles per step; tempo 3 -> 2 cycles per step. Switching tempo from 0 to 2 when counter=10 -> step ends on the next cycle.
- ARTIC=1, tempo=1 -> tone is SILENCE on the last cycle of each 8-cycle step. start and stop in the same cycle -> remains IDLE.
- rst asserted mid-song at beat 2 -> all outputs take their reset values on the next edge. A subsequent start plays from index 0.
